// File: rtl/alu_op_decoder.sv
// alu_op_decoder: MIPS R-type decode stage between fetch and execute.
//
// Raw 32-bit instruction words arrive on a valid/ready input port, are
// decoded combinationally into a 5-bit ALU op code plus register/shamt
// fields, and are held in a 2-entry FIFO skid buffer. The head entry drives
// out_* directly from registers.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid && ready are both high. A producer holding valid high must
// keep its payload stable until the transfer. in_ready is a registered
// function of buffer occupancy only, so there is no combinational path from
// out_ready to in_ready.
//
// Build option: define ALU_DEC_SRA_EN to decode funct 0x03 as sra (op 10).
// Without it, funct 0x03 is illegal (op 12, illegal=1) and is counted.
//
// dbg_state exposes the occupancy FSM (0=EMPTY, 1=ONE, 2=FULL).
module alu_op_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_op_code,
  output logic [4:0]       out_shamt,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count,
  output logic [1:0]       dbg_state
);

  // ALU operation codes.
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADDU = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_SUBU = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_OR   = 5'd5;
  localparam logic [4:0] OP_XOR  = 5'd6;
  localparam logic [4:0] OP_SLT  = 5'd7;
  localparam logic [4:0] OP_SLL  = 5'd8;
  localparam logic [4:0] OP_SRL  = 5'd9;
`ifdef ALU_DEC_SRA_EN
  localparam logic [4:0] OP_SRA  = 5'd10;
`endif
  localparam logic [4:0] OP_JR   = 5'd11;
  localparam logic [4:0] OP_NOP  = 5'd12;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // One buffered entry: decoded fields only, never the raw word.
  typedef struct packed {
    logic [4:0] op;
    logic [4:0] shamt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       illegal;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           state_q;
  entry_t           head_q;
  entry_t           tail_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  entry_t dec_entry;
  logic   accept;
  logic   pop;

  // Field extraction and op-code lookup for one instruction word.
  function automatic entry_t decode(input logic [31:0] w);
    entry_t e;
    e.op      = OP_NOP;
    e.shamt   = w[10:6];
    e.rs      = w[25:21];
    e.rt      = w[20:16];
    e.rd      = w[15:11];
    e.illegal = 1'b0;
    if (w == 32'h0000_0000) begin
      // All-zero word is the canonical nop, even though it looks like sll.
      e.op = OP_NOP;
    end else if (w[31:26] != 6'h00) begin
      // Only R-type words are supported by this stage.
      e.illegal = 1'b1;
    end else begin
      case (w[5:0])
        6'h20:   e.op = OP_ADD;
        6'h21:   e.op = OP_ADDU;
        6'h22:   e.op = OP_SUB;
        6'h23:   e.op = OP_SUBU;
        6'h24:   e.op = OP_AND;
        6'h25:   e.op = OP_OR;
        6'h26:   e.op = OP_XOR;
        6'h2A:   e.op = OP_SLT;
        6'h00:   e.op = OP_SLL;
        6'h02:   e.op = OP_SRL;
`ifdef ALU_DEC_SRA_EN
        6'h03:   e.op = OP_SRA;
`endif
        6'h08:   e.op = OP_JR;
        default: e.illegal = 1'b1;
      endcase
    end
    return e;
  endfunction

  // Decode is purely combinational on the word being offered.
  always_comb begin
    dec_entry = decode(in_instr);
  end

  // Transfers; flush swallows the input word so it is neither stored nor counted.
  always_comb begin
    accept = in_valid && in_ready_q && !flush;
    pop    = out_valid_q && out_ready;
  end

  // Saturating illegal counter, next value.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && dec_entry.illegal && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Occupancy FSM with registered head/tail entries and handshake flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      // Entries are dropped; payload registers keep stale contents.
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            head_q      <= dec_entry;
            state_q     <= S_ONE;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b1;
          end
        end
        S_ONE: begin
          case ({accept, pop})
            2'b10: begin
              // Head is stalled: new word parks in the skid slot.
              tail_q     <= dec_entry;
              state_q    <= S_FULL;
              in_ready_q <= 1'b0;
            end
            2'b01: begin
              state_q     <= S_EMPTY;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
            end
            2'b11: begin
              // Pass-through: the new word becomes the head directly.
              head_q <= dec_entry;
            end
            default: begin
              head_q <= head_q;
            end
          endcase
        end
        S_FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            head_q     <= tail_q;
            state_q    <= S_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Illegal counter register; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Output mapping from the head entry and flag registers.
  always_comb begin
    in_ready      = in_ready_q;
    out_valid     = out_valid_q;
    out_op_code   = head_q.op;
    out_shamt     = head_q.shamt;
    out_rs        = head_q.rs;
    out_rt        = head_q.rt;
    out_rd        = head_q.rd;
    out_illegal   = head_q.illegal;
    illegal_count = cnt_q;
    dbg_state     = state_q;
  end

endmodule
